// File: rtl/peak_window_tracker.sv
// Windowed peak tracker: collects WINDOW samples, reports max, min and the number
// of samples equal to the final max, then holds the result until the consumer takes it.
//
// state  | meaning
// IDLE   | no sample in the current window
// ACCUM  | 1..WINDOW-1 samples taken, running max/min/hits visible
// REPORT | window complete, result held with out_valid=1
module peak_window_tracker #(
    parameter int unsigned WINDOW = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] max_val,
    output logic [15:0] min_val,
    output logic [7:0]  max_hits
);

    localparam logic [7:0] WIN = 8'(WINDOW);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] count;
    logic [7:0] count_inc;
    logic       accept;

    assign in_ready  = (state != REPORT);
    assign accept    = in_valid && in_ready;
    assign count_inc = count + 8'd1;

    always_ff @(posedge clk) begin
        // clear shares the reset path; rst still wins because both land in the same state
        if (rst || clear) begin
            state     <= IDLE;
            count     <= 8'd0;
            out_valid <= 1'b0;
            max_val   <= 16'd0;
            min_val   <= 16'd0;
            max_hits  <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        max_val  <= in_data;
                        min_val  <= in_data;
                        max_hits <= 8'd1;
                        count    <= 8'd1;
                        if (WIN == 8'd1) begin
                            state     <= REPORT;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (in_data > max_val) begin
                            max_val  <= in_data;
                            max_hits <= 8'd1;
                        end else if (in_data == max_val && max_hits != 8'hFF) begin
                            max_hits <= max_hits + 8'd1;
                        end
                        if (in_data < min_val)
                            min_val <= in_data;
                        count <= count_inc;
                        if (count_inc == WIN) begin
                            state     <= REPORT;
                            out_valid <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    // results stay as running values until the next window's first sample
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        count     <= 8'd0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    count     <= 8'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/peak_window_tracker.md
PEAK_WINDOW_TRACKER -- requirements
Module: peak_window_tracker

Interface
REQ-001 The block SHALL have parameter WINDOW, default 8, giving samples per window (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port clear  input  1  synchronous soft clear.
REQ-005 The block SHALL have port in_valid  input  1  in_data holds a valid sample.
REQ-006 The block SHALL have port in_data  input  16  unsigned sample.
REQ-007 The block SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 The block SHALL have port out_valid  output  1  window result is available.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 The block SHALL have port max_val  output  16  largest sample in the window.
REQ-011 The block SHALL have port min_val  output  16  smallest sample in the window.
REQ-012 The block SHALL have port max_hits  output  8  count of window samples equal to the final max_val.

Function
REQ-013 The block SHALL implement FSM states IDLE (no sample in window), ACCUM (1..WINDOW-1 samples taken) and REPORT (result held).
REQ-014 A sample SHALL be accepted only on a cycle where in_valid=1 and in_ready=1.
REQ-015 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in REPORT.
REQ-016 The first accepted sample of a window SHALL load max_val=min_val=in_data, max_hits=1 and sample count=1.
REQ-017 On a later accepted sample where in_data>max_val, the block SHALL load max_val=in_data and max_hits=1.
REQ-018 On a later accepted sample where in_data==max_val, the block SHALL increment max_hits, saturating at 255.
REQ-019 On a later accepted sample where in_data<min_val, the block SHALL load min_val=in_data.
REQ-020 All comparisons SHALL be 16-bit unsigned (gt/lt/eq semantics), and max/min updates SHALL take effect in the same cycle.
REQ-021 The state SHALL move IDLE->ACCUM on the first accepted sample when WINDOW>1.
REQ-022 The state SHALL move to REPORT on the accepted sample that makes the count equal WINDOW.
REQ-023 With WINDOW=1, every accepted sample SHALL move IDLE->REPORT directly.
REQ-024 out_valid SHALL assert on the cycle after the WINDOW-th handshake (latency 1) and remain 1 until out_valid&&out_ready.
REQ-025 max_val, min_val and max_hits SHALL remain stable while out_valid=1.
REQ-026 When out_valid&&out_ready, the FSM SHALL move REPORT->IDLE, and out_valid SHALL be 0 on the next cycle.
REQ-027 No sample SHALL be accepted in the release cycle, since in_ready is still 0 there.
REQ-028 A stalled in_valid (in_valid=0) SHALL leave all state unchanged.
REQ-029 A stalled consumer (out_ready=0) SHALL hold REPORT indefinitely.
REQ-030 In IDLE and ACCUM, max_val/min_val/max_hits SHALL show running values, and consumers SHALL sample them only when out_valid=1.
REQ-031 clear=1 SHALL return the block to IDLE from any state on the next edge, zero all outputs and counters, and drop any sample presented that cycle.

Reset
REQ-032 rst SHALL take priority over clear and over all handshakes.
REQ-033 After rst, the state SHALL be IDLE, out_valid=0, max_val=0, min_val=0, max_hits=0, internal count=0, and in_ready=1.
REQ-034 rst asserted in ACCUM or REPORT SHALL discard the partial or pending result without emitting it.

Verification
REQ-035 WINDOW=4, samples 5,9,9,2 with out_ready=1 -> out_valid one cycle after the 4th sample, with max_val=9, min_val=2, max_hits=2.
REQ-036 WINDOW=4, samples 0xFFFF,0x0000,0x8000,0xFFFF with out_ready=0 for 10 cycles -> outputs 0xFFFF/0x0000/2 held stable and in_ready=0 throughout; out_ready=1 then gives out_valid=0 on the next cycle.
REQ-037 WINDOW=1, samples 7 then 3 back-to-back with out_ready=1 -> two results (7/7/1) and (3/3/1), and the second sample is not accepted during the first REPORT cycle.
REQ-038 WINDOW=255, 255 samples of 0x1234 -> max_hits=255 (saturation boundary), with max_val=min_val=0x1234.
REQ-039 WINDOW=4, after 2 samples assert clear (or rst) -> IDLE with outputs 0; next samples 1,2,3,4 give 4/1/1 with no stale data.
REQ-040 rst and clear asserted together in REPORT -> rst behaviour (REQ-033), and out_valid=0 on the next cycle.
